text_console_writer: RTL

TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

---
 rtl/text_console_writer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - character-cell console writer driving a glyph memory with cursor control and screen clear
module text_console_writer #(
    parameter int         COLS  = 80,
    parameter int         ROWS  = 60,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    input  logic [7:0]  char_attr,
    output logic        char_ready,
    input  logic        clear_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wd,
    output logic        busy,
    output logic [6:0]  cursor_col,
    output logic [5:0]  cursor_row
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
    localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);
    localparam logic [15:0] COLS16   = 16'(COLS);
    localparam logic [15:0] CELLS    = 16'(COLS * ROWS);

    state_t      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [5:0]  row_q, row_d;
    logic [15:0] base_q, base_d;        // row_q * COLS, tracked incrementally
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wd_q, mem_wd_d;
    logic [7:0]  clr_attr_q, clr_attr_d;
    logic [15:0] clr_cnt_q, clr_cnt_d;  // next clear address to issue

    logic        accept;
    logic [15:0] cur_addr;
    logic [5:0]  nl_row;
    logic [15:0] nl_base;

    assign char_ready = (state_q == IDLE) && !clear_req;
    assign accept     = char_valid && char_ready;
    assign cur_addr   = base_q + {9'd0, col_q};

    // Row/base the cursor moves to on a line advance, wrapping to the top without scrolling
    always_comb begin
        nl_row  = row_q + 6'd1;
        nl_base = base_q + COLS16;
        if (row_q == LAST_ROW) begin
            nl_row  = 6'd0;
            nl_base = 16'd0;
        end
    end

    // Next-state, cursor and registered write-port logic
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        base_d     = base_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        clr_attr_d = clr_attr_q;
        clr_cnt_d  = clr_cnt_q;
        case (state_q)
            IDLE: begin
                if (clear_req || (accept && char_data == 8'h0C)) begin
                    // First clear write goes out on the entry edge so busy covers every write
                    state_d    = CLEAR;
                    clr_attr_d = char_attr;
                    mem_we_d   = 1'b1;
                    mem_addr_d = 16'd0;
                    mem_wd_d   = {char_attr, BLANK};
                    clr_cnt_d  = 16'd1;
                end else if (accept) begin
                    if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = cur_addr;
                        mem_wd_d   = {char_attr, char_data};
                        if (col_q == LAST_COL) begin
                            col_d  = 7'd0;
                            row_d  = nl_row;
                            base_d = nl_base;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (char_data)
                            8'h0A: begin
                                col_d  = 7'd0;
                                row_d  = nl_row;
                                base_d = nl_base;
                            end
                            8'h0D: col_d = 7'd0;
                            8'h08: begin
                                // The cell behind the cursor is cur_addr-1 whether or not we wrap rows
                                if (col_q != 7'd0) begin
                                    col_d      = col_q - 7'd1;
                                    mem_we_d   = 1'b1;
                                    mem_addr_d = cur_addr - 16'd1;
                                    mem_wd_d   = {char_attr, BLANK};
                                end else if (row_q != 6'd0) begin
                                    col_d      = LAST_COL;
                                    row_d      = row_q - 6'd1;
                                    base_d     = base_q - COLS16;
                                    mem_we_d   = 1'b1;
                                    mem_addr_d = cur_addr - 16'd1;
                                    mem_wd_d   = {char_attr, BLANK};
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CLEAR: begin
                if (clr_cnt_q == CELLS) begin
                    state_d = IDLE;
                    col_d   = 7'd0;
                    row_d   = 6'd0;
                    base_d  = 16'd0;
                end else begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = clr_cnt_q;
                    mem_wd_d   = {clr_attr_q, BLANK};
                    clr_cnt_d  = clr_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            col_q      <= 7'd0;
            row_q      <= 6'd0;
            base_q     <= 16'd0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 16'd0;
            mem_wd_q   <= 16'd0;
            clr_attr_q <= 8'd0;
            clr_cnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            base_q     <= base_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            clr_attr_q <= clr_attr_d;
            clr_cnt_q  <= clr_cnt_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wd     = mem_wd_q;
    assign busy       = (state_q == CLEAR);
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule
